// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op codes, state encoding and iteration count for muldiv_unit
package muldiv_pkg;
   localparam int DATA_W = 64;
   localparam int ITER = DATA_W;
   localparam logic [1:0] OP_MUL = 2'b00;
   localparam logic [1:0] OP_MUL_ALT = 2'b01;
   localparam logic [1:0] OP_UDIV = 2'b10;
   localparam logic [1:0] OP_SDIV = 2'b11;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between the controller and muldiv_unit
interface muldiv_if #(parameter int WIDTH = 64);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [4:0]       rd_in;
   logic             busy;
   logic             done;
   logic             reg_wr;
   logic [WIDTH-1:0] result;
   logic [4:0]       rd_out;
   modport master (output start, op, a, b, rd_in, input busy, done, reg_wr, result, rd_out);
   modport slave (input start, op, a, b, rd_in, output busy, done, reg_wr, result, rd_out);
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add multiply or restoring-divide iteration
module muldiv_step #(parameter int WIDTH = 64) (
   input  logic             is_div,
   input  logic [WIDTH-1:0] acc,
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] opd,
   output logic [WIDTH-1:0] acc_n,
   output logic [WIDTH-1:0] rem_n,
   output logic [WIDTH-1:0] quo_n,
   output logic [WIDTH-1:0] opd_n
);
   logic [WIDTH:0] rem_sh;
   logic [WIDTH:0] diff;
   logic           ge;
   always_comb begin
      rem_sh = {rem, quo[WIDTH-1]};
      diff = rem_sh - {1'b0, opd};
      ge = !diff[WIDTH];
      acc_n = is_div ? acc : acc + (quo[0] ? opd : '0);
      rem_n = is_div ? (ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]) : rem;
      quo_n = is_div ? {quo[WIDTH-2:0], ge} : quo >> 1;
      opd_n = is_div ? opd : opd << 1;
   end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MUL/UDIV/SDIV unit, one bit per cycle, result to the register-file write port
module muldiv_unit
   import muldiv_pkg::*;
#(parameter int WIDTH = ITER) (
   input logic     clk,
   input logic     reset,
   muldiv_if.slave io
);
   state_t           state_q, state_d;
   logic [6:0]       cnt_q, cnt_d;
   logic             is_div_q, is_div_d, neg_q, neg_d;
   logic [4:0]       rd_q, rd_d;
   logic [WIDTH-1:0] acc_q, acc_d, rem_q, rem_d, quo_q, quo_d, opd_q, opd_d, res_q, res_d;
   logic [WIDTH-1:0] acc_n, rem_n, quo_n, opd_n, abs_a, abs_b;
   logic             div_op, sdiv_op, div_zero;
   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div(is_div_q), .acc(acc_q), .rem(rem_q), .quo(quo_q), .opd(opd_q),
      .acc_n(acc_n), .rem_n(rem_n), .quo_n(quo_n), .opd_n(opd_n)
   );
   always_comb begin
      div_op = io.op == OP_UDIV || io.op == OP_SDIV;
      sdiv_op = io.op == OP_SDIV;
      div_zero = div_op && io.b == '0;
      abs_a = sdiv_op && io.a[WIDTH-1] ? -io.a : io.a;
      abs_b = sdiv_op && io.b[WIDTH-1] ? -io.b : io.b;
      state_d = state_q;
      cnt_d = cnt_q;
      is_div_d = is_div_q;
      neg_d = neg_q;
      rd_d = rd_q;
      acc_d = acc_q;
      rem_d = rem_q;
      quo_d = quo_q;
      opd_d = opd_q;
      res_d = res_q;
      unique case (state_q)
         IDLE: if (io.start) begin
            state_d = div_zero ? DONE : RUN;
            cnt_d = '0;
            is_div_d = div_op;
            neg_d = sdiv_op && (io.a[WIDTH-1] ^ io.b[WIDTH-1]);
            rd_d = io.rd_in;
            acc_d = '0;
            rem_d = '0;
            quo_d = div_op ? abs_a : io.b;
            opd_d = div_op ? abs_b : io.a;
            res_d = div_zero ? '0 : res_q;
         end
         RUN: begin
            acc_d = acc_n;
            rem_d = rem_n;
            quo_d = quo_n;
            opd_d = opd_n;
            cnt_d = cnt_q + 7'd1;
            if (cnt_q == 7'(WIDTH - 1)) begin
               state_d = DONE;
               res_d = is_div_q ? (neg_q ? -quo_n : quo_n) : acc_n;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q <= '0;
         is_div_q <= 1'b0;
         neg_q <= 1'b0;
         rd_q <= '0;
         acc_q <= '0;
         rem_q <= '0;
         quo_q <= '0;
         opd_q <= '0;
         res_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         is_div_q <= is_div_d;
         neg_q <= neg_d;
         rd_q <= rd_d;
         acc_q <= acc_d;
         rem_q <= rem_d;
         quo_q <= quo_d;
         opd_q <= opd_d;
         res_q <= res_d;
      end
   end
   assign io.busy = state_q != IDLE;
   assign io.done = state_q == DONE;
   assign io.reg_wr = state_q == DONE;
   assign io.result = res_q;
   assign io.rd_out = rd_q;
endmodule
